// File: rtl/rgb_fade_engine.sv
// rgb_fade_engine: N-channel PWM colour fader with hue-wheel, breathe and freeze modes.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           1 = run, 0 = hold all counters and force outputs low
//   mode         0 hue-wheel, 1 breathe, 2/3 freeze
//   ch_mask      per-channel output enable
//   pwm_out      registered PWM outputs, one per channel
//   segment      current fade segment, 0..5
//   period_tick  high during the last cycle of each PWM period
module rgb_fade_engine #(
   parameter int unsigned PWM_INTERVAL     = 1200,
   parameter int unsigned DUTY_STEP        = 20,
   parameter int unsigned PERIODS_PER_STEP = 100,
   parameter int unsigned NUM_CH           = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [2:0]        segment,
   output logic              period_tick
);

   localparam int unsigned NSTEPS = PWM_INTERVAL / DUTY_STEP;
   localparam int unsigned PW     = (PWM_INTERVAL > 1)     ? $clog2(PWM_INTERVAL)     : 1;
   localparam int unsigned SW     = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam int unsigned LW     = (NSTEPS > 1)           ? $clog2(NSTEPS)           : 1;
   localparam int unsigned DW     = $clog2(PWM_INTERVAL + 1);

   localparam logic [PW-1:0] PCNT_LAST = PW'(PWM_INTERVAL - 1);
   localparam logic [SW-1:0] SCNT_LAST = SW'(PERIODS_PER_STEP - 1);
   localparam logic [LW-1:0] LVL_LAST  = LW'(NSTEPS - 1);

   typedef enum logic [1:0] {SH_HIGH, SH_FALL, SH_LOW, SH_RISE} shape_t;

   logic [PW-1:0] pcnt, pcnt_nxt_c;
   logic [SW-1:0] scnt, scnt_nxt_c;
   logic [LW-1:0] lvl, lvl_nxt_c;
   logic [2:0]    seg_nxt_c;
   logic          wrap_c;
   logic          advance_c;
   logic [DW-1:0] duty_q     [NUM_CH];
   logic [DW-1:0] duty_nxt_c [NUM_CH];

   // Hue-wheel shape: each channel is phase-shifted by two segments.
   function automatic shape_t hue_shape(input logic [2:0] seg, input int unsigned ch);
      int unsigned ls;
      shape_t      sh;
      ls = (32'(seg) + 32'd6 - ((32'd2 * ch) % 32'd6)) % 32'd6;
      case (ls)
         32'd0:   sh = SH_HIGH;
         32'd1:   sh = SH_FALL;
         32'd2:   sh = SH_LOW;
         32'd3:   sh = SH_LOW;
         32'd4:   sh = SH_RISE;
         default: sh = SH_HIGH;
      endcase
      return sh;
   endfunction

   // Map a shape and ramp level to a duty value in clk cycles.
   function automatic logic [DW-1:0] duty_of(input shape_t sh, input logic [LW-1:0] l);
      logic [DW-1:0] ramp;
      logic [DW-1:0] d;
      ramp = DW'(l) * DW'(DUTY_STEP);
      case (sh)
         SH_HIGH: d = DW'(PWM_INTERVAL);
         SH_FALL: d = DW'(PWM_INTERVAL) - ramp;
         SH_RISE: d = ramp;
         default: d = '0;
      endcase
      return d;
   endfunction

   // Next-state for the period/step/level/segment counter chain.
   always_comb begin
      wrap_c     = (pcnt == PCNT_LAST);
      advance_c  = en && wrap_c && !mode[1];
      pcnt_nxt_c = pcnt;
      scnt_nxt_c = scnt;
      lvl_nxt_c  = lvl;
      seg_nxt_c  = segment;
      if (en) begin
         pcnt_nxt_c = wrap_c ? '0 : pcnt + PW'(1);
      end
      if (advance_c) begin
         if (scnt == SCNT_LAST) begin
            scnt_nxt_c = '0;
            if (lvl == LVL_LAST) begin
               lvl_nxt_c = '0;
               seg_nxt_c = (segment == 3'd5) ? 3'd0 : segment + 3'd1;
            end else begin
               lvl_nxt_c = lvl + LW'(1);
            end
         end else begin
            scnt_nxt_c = scnt + SW'(1);
         end
      end
   end

   // Duty candidates use the level/segment as they will be after this wrap.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         duty_nxt_c[i] = '0;
         if (mode == 2'd1) begin
            duty_nxt_c[i] = duty_of(seg_nxt_c[0] ? SH_FALL : SH_RISE, lvl_nxt_c);
         end else begin
            duty_nxt_c[i] = duty_of(hue_shape(seg_nxt_c, i), lvl_nxt_c);
         end
      end
   end

   // State and output registers; duty only reloads at a running-mode period wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt        <= '0;
         scnt        <= '0;
         lvl         <= '0;
         segment     <= '0;
         period_tick <= 1'b0;
         pwm_out     <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            duty_q[i] <= '0;
         end
      end else begin
         pcnt        <= pcnt_nxt_c;
         scnt        <= scnt_nxt_c;
         lvl         <= lvl_nxt_c;
         segment     <= seg_nxt_c;
         period_tick <= en && (pcnt_nxt_c == PCNT_LAST);
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (advance_c) begin
               duty_q[i] <= duty_nxt_c[i];
            end
            pwm_out[i] <= en && ch_mask[i] && (DW'(pcnt) < duty_q[i]);
         end
      end
   end

endmodule

// File: tb/tb_rgb_fade_engine.sv
// tb_rgb_fade_engine: directed bench for rgb_fade_engine with a small PWM configuration
// (interval 10, step 2, 2 periods per step, 3 channels).
module tb_rgb_fade_engine;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [2:0] ch_mask;
   logic [2:0] pwm_out;
   logic [2:0] segment;
   logic       period_tick;

   int checks = 0;
   int errors = 0;

   rgb_fade_engine #(
      .PWM_INTERVAL(10),
      .DUTY_STEP(2),
      .PERIODS_PER_STEP(2),
      .NUM_CH(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .mode(mode),
      .ch_mask(ch_mask),
      .pwm_out(pwm_out),
      .segment(segment),
      .period_tick(period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record = n consecutive PWM periods with fixed inputs and expected high counts.
   typedef struct {
      logic [1:0] mode;
      logic [2:0] mask;
      int         n;
      int         e0;
      int         e1;
      int         e2;
      int         seg;
   } vec_t;

   vec_t hue_tab [11];
   vec_t br_tab  [13];
   vec_t fr_tab  [9];

   function automatic vec_t mk(input logic [1:0] m, input logic [2:0] k, input int n,
                               input int e0, input int e1, input int e2, input int s);
      vec_t v;
      v.mode = m; v.mask = k; v.n = n; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.seg = s;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reset held across edges, then released on a falling edge so the next rising edge is cycle 1.
   task automatic do_reset();
      rst_n   = 1'b0;
      en      = 1'b0;
      mode    = 2'd0;
      ch_mask = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      check("reset pwm_out", int'(pwm_out), 0);
      check("reset segment", int'(segment), 0);
      check("reset tick", int'(period_tick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
   endtask

   // Measure v.n whole periods; called just after a period boundary edge.
   task automatic run_vec(input string tag, input vec_t v);
      int c0, c1, c2;
      for (int p = 0; p < v.n; p++) begin
         mode    = v.mode;
         ch_mask = v.mask;
         en      = 1'b1;
         c0 = 0; c1 = 0; c2 = 0;
         for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check($sformatf("%s seg p%0d", tag, p), int'(segment), v.seg);
            check($sformatf("%s tick p%0d k%0d", tag, p, k), int'(period_tick), int'(k == 9));
            c0 += pwm_out[0] ? 1 : 0;
            c1 += pwm_out[1] ? 1 : 0;
            c2 += pwm_out[2] ? 1 : 0;
         end
         check($sformatf("%s ch0 p%0d", tag, p), c0, v.e0);
         check($sformatf("%s ch1 p%0d", tag, p), c1, v.e1);
         check($sformatf("%s ch2 p%0d", tag, p), c2, v.e2);
      end
   endtask

   initial begin
      // Hue-wheel from reset: ch0 HIGH/FALL, ch1 RISE/HIGH, ch2 LOW through segments 0 and 1.
      hue_tab[0]  = mk(2'd0, 3'b111, 1,  0,  0, 0, 0);
      hue_tab[1]  = mk(2'd0, 3'b111, 1, 10,  0, 0, 0);
      hue_tab[2]  = mk(2'd0, 3'b111, 2, 10,  2, 0, 0);
      hue_tab[3]  = mk(2'd0, 3'b111, 2, 10,  4, 0, 0);
      hue_tab[4]  = mk(2'd0, 3'b111, 2, 10,  6, 0, 0);
      hue_tab[5]  = mk(2'd0, 3'b111, 2, 10,  8, 0, 0);
      hue_tab[6]  = mk(2'd0, 3'b111, 2, 10, 10, 0, 1);
      hue_tab[7]  = mk(2'd0, 3'b111, 2,  8, 10, 0, 1);
      hue_tab[8]  = mk(2'd0, 3'b111, 2,  6, 10, 0, 1);
      hue_tab[9]  = mk(2'd0, 3'b111, 2,  4, 10, 0, 1);
      hue_tab[10] = mk(2'd0, 3'b111, 2,  2, 10, 0, 1);

      // Breathe: all channels share RISE (even segment) / FALL (odd), with some masking.
      br_tab[0]  = mk(2'd1, 3'b111, 1,  0,  0,  0, 0);
      br_tab[1]  = mk(2'd1, 3'b111, 1,  0,  0,  0, 0);
      br_tab[2]  = mk(2'd1, 3'b111, 2,  2,  2,  2, 0);
      br_tab[3]  = mk(2'd1, 3'b101, 2,  4,  0,  4, 0);
      br_tab[4]  = mk(2'd1, 3'b111, 2,  6,  6,  6, 0);
      br_tab[5]  = mk(2'd1, 3'b111, 2,  8,  8,  8, 0);
      br_tab[6]  = mk(2'd1, 3'b111, 2, 10, 10, 10, 1);
      br_tab[7]  = mk(2'd1, 3'b111, 2,  8,  8,  8, 1);
      br_tab[8]  = mk(2'd1, 3'b010, 2,  0,  6,  0, 1);
      br_tab[9]  = mk(2'd1, 3'b111, 2,  4,  4,  4, 1);
      br_tab[10] = mk(2'd1, 3'b111, 2,  2,  2,  2, 1);
      br_tab[11] = mk(2'd1, 3'b111, 2,  0,  0,  0, 2);
      br_tab[12] = mk(2'd1, 3'b111, 2,  2,  2,  2, 2);

      // Freeze at lvl 3 of ch1 RISE for 50 periods, then resume the ramp.
      fr_tab[0] = mk(2'd0, 3'b111,  1,  0,  0, 0, 0);
      fr_tab[1] = mk(2'd0, 3'b111,  1, 10,  0, 0, 0);
      fr_tab[2] = mk(2'd0, 3'b111,  2, 10,  2, 0, 0);
      fr_tab[3] = mk(2'd0, 3'b111,  2, 10,  4, 0, 0);
      fr_tab[4] = mk(2'd2, 3'b111, 25, 10,  6, 0, 0);
      fr_tab[5] = mk(2'd3, 3'b111, 25, 10,  6, 0, 0);
      fr_tab[6] = mk(2'd0, 3'b111,  2, 10,  6, 0, 0);
      fr_tab[7] = mk(2'd0, 3'b111,  2, 10,  8, 0, 0);
      fr_tab[8] = mk(2'd0, 3'b111,  1, 10, 10, 0, 1);

      do_reset();
      for (int i = 0; i < 11; i++) run_vec($sformatf("hue%0d", i), hue_tab[i]);

      // Segment 2 running, then reset asserted between clock edges.
      repeat (9) @(posedge clk);
      #1;
      check("pre-reset pwm_out", int'(pwm_out), 3'b010);
      check("pre-reset segment", int'(segment), 2);
      check("pre-reset tick", int'(period_tick), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async pwm_out", int'(pwm_out), 0);
      check("async segment", int'(segment), 0);
      check("async tick", int'(period_tick), 0);

      // Full wheel: segment 5 just before cycle 600, back to 0 at cycle 600.
      do_reset();
      repeat (599) @(posedge clk);
      #1;
      check("wheel seg@599", int'(segment), 5);
      @(posedge clk);
      #1;
      check("wheel seg@600", int'(segment), 0);

      do_reset();
      for (int i = 0; i < 13; i++) run_vec($sformatf("br%0d", i), br_tab[i]);

      do_reset();
      for (int i = 0; i < 9; i++) run_vec($sformatf("fr%0d", i), fr_tab[i]);

      // Enable dropped mid-period at lvl 3, then resumed with only ch1 unmasked.
      do_reset();
      for (int i = 0; i < 4; i++) run_vec($sformatf("en%0d", i), hue_tab[i]);
      repeat (3) @(posedge clk);
      #1;
      check("en mid pwm_out", int'(pwm_out), 3'b011);
      en = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("en off pwm k%0d", k), int'(pwm_out), 0);
         check($sformatf("en off tick k%0d", k), int'(period_tick), 0);
      end
      check("en off segment", int'(segment), 0);
      en      = 1'b1;
      ch_mask = 3'b010;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("resume pwm k%0d", k), int'(pwm_out), (k <= 3) ? 3'b010 : 3'b000);
         check($sformatf("resume tick k%0d", k), int'(period_tick), int'(k == 6));
      end
      run_vec("resume p7", mk(2'd0, 3'b010, 1, 0, 6, 0, 0));
      run_vec("resume p8", mk(2'd0, 3'b010, 1, 0, 8, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
